sfifo_param: RTL and testbench

Parametrised synchronous single-clock FIFO. It is the next-generation replacement for the fixed 8x16 FIFO in the user project.
- Adds configurable data width and depth, occupancy count, and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags, an output-valid strobe, and an optional first-word-fall-through (FWFT) mode.
- Sits between GPIO/LA-driven producers and consumers inside user_proj_example.

---
 rtl/sfifo_param_if.sv | 32 +++
 rtl/sfifo_param.sv | 137 +++++++++++++
 tb/tb_sfifo_param.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sfifo_param_if.sv
// Handshake and status bundle for the parametrised synchronous FIFO.
// The producer/consumer side uses the master view; the FIFO uses the slave view.
interface sfifo_param_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          write;
    logic          read;
    logic          clr_err;
    logic [DW-1:0] iData;
    logic [DW-1:0] oData;
    logic          valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output write, read, clr_err, iData,
        input  oData, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write, read, clr_err, iData,
        output oData, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and an optional
// first-word-fall-through read port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sfifo_param #(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    sfifo_param_if.slave      bus
);

    localparam int DEPTH = 1 << AW;

    logic [AW:0]   wp_q,    wp_d;
    logic [AW:0]   rp_q,    rp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          valid_q, valid_d;
    logic          ovf_q,   ovf_d;
    logic          unf_q,   unf_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          full_s;
    logic          empty_s;
    logic [AW:0]   count_s;
    logic          push_s;
    logic          pop_s;
    logic [DW-1:0] head_s;

    // Decode occupancy flags from the registered pointers and qualify requests.
    always_comb begin
        full_s  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        empty_s = (wp_q == rp_q);
        count_s = wp_q - rp_q;
        push_s  = bus.write && !full_s;
        pop_s   = bus.read  && !empty_s;
        head_s  = mem_q[rp_q[AW-1:0]];
    end

    // Next-state for pointers, sticky errors and the registered read port.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (push_s) begin
            wp_d = wp_q + (AW+1)'(1);
        end else begin
            wp_d = wp_q;
        end

        if (pop_s) begin
            rp_d = rp_q + (AW+1)'(1);
        end else begin
            rp_d = rp_q;
        end

        // In FWFT mode the head is shown combinationally, so these stay idle.
        if (FWFT == 0 && pop_s) begin
            rdata_d = head_s;
            valid_d = 1'b1;
        end else begin
            rdata_d = rdata_q;
            valid_d = 1'b0;
        end

        // A new error event in the same cycle as a clear takes priority.
        if (bus.write && full_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (bus.read && empty_s) begin
            unf_d = 1'b1;
        end else if (bus.clr_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wp_q    <= '0;
            rp_q    <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wp_q[AW-1:0]] <= bus.iData;
        end
    end

    // Drive the status outputs and select the read-port flavour.
    always_comb begin
        bus.full         = full_s;
        bus.empty        = empty_s;
        bus.count        = count_s;
        bus.almost_full  = (count_s >= (AW+1)'(AF_LEVEL));
        bus.almost_empty = (count_s <= (AW+1)'(AE_LEVEL));
        bus.overflow     = ovf_q;
        bus.underflow    = unf_q;
        if (FWFT != 0) begin
            bus.oData = empty_s ? {DW{1'b0}} : head_s;
            bus.valid = !empty_s;
        end else begin
            bus.oData = rdata_q;
            bus.valid = valid_q;
        end
    end

endmodule

// File: tb/tb_sfifo_param.sv
// Self-checking bench for sfifo_param: one registered-read and one FWFT
// instance share the same stimulus and are compared every cycle against a
// queue-based reference, with hand-computed spot checks along the way.
module tb_sfifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          CLK;
    logic          RSTn;
    logic          w, r, c;
    logic [DW-1:0] d;

    int n_cmp = 0;
    int n_bad = 0;

    sfifo_param_if #(.DW(DW), .AW(AW)) if0 ();
    sfifo_param_if #(.DW(DW), .AW(AW)) if1 ();

    assign if0.write   = w;
    assign if0.read    = r;
    assign if0.clr_err = c;
    assign if0.iData   = d;
    assign if1.write   = w;
    assign if1.read    = r;
    assign if1.clr_err = c;
    assign if1.iData   = d;

    sfifo_param #(.DW(DW), .AW(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (if0)
    );

    sfifo_param #(.DW(DW), .AW(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (if1)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus the error flags and
    // the registered read-port value.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] odata_m = 8'h00;
    logic          valid_m = 1'b0;
    logic          ovf_m   = 1'b0;
    logic          unf_m   = 1'b0;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mq.delete();
            odata_m <= 8'h00;
            valid_m <= 1'b0;
            ovf_m   <= 1'b0;
            unf_m   <= 1'b0;
        end else begin
            if (w && mq.size() == DEPTH) ovf_m <= 1'b1;
            else if (c)                  ovf_m <= 1'b0;
            if (r && mq.size() == 0)     unf_m <= 1'b1;
            else if (c)                  unf_m <= 1'b0;
            if (r && mq.size() != 0) begin
                if (w && mq.size() != DEPTH) mq.push_back(d);
                odata_m <= mq[0];
                valid_m <= 1'b1;
                mq.pop_front();
            end else begin
                valid_m <= 1'b0;
                if (w && mq.size() != DEPTH) mq.push_back(d);
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge CLK) begin
        chk("count",        32'(if0.count),        32'(mq.size()));
        chk("full",         32'(if0.full),         32'(mq.size() == DEPTH));
        chk("empty",        32'(if0.empty),        32'(mq.size() == 0));
        chk("almost_full",  32'(if0.almost_full),  32'(mq.size() >= 14));
        chk("almost_empty", 32'(if0.almost_empty), 32'(mq.size() <= 2));
        chk("overflow",     32'(if0.overflow),     32'(ovf_m));
        chk("underflow",    32'(if0.underflow),    32'(unf_m));
        chk("reg_oData",    32'(if0.oData),        32'(odata_m));
        chk("reg_valid",    32'(if0.valid),        32'(valid_m));
        chk("fwft_count",   32'(if1.count),        32'(mq.size()));
        chk("fwft_uflow",   32'(if1.underflow),    32'(unf_m));
        chk("fwft_oData",   32'(if1.oData),        (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk("fwft_valid",   32'(if1.valid),        32'(mq.size() != 0));
    end

    // One clock of stimulus; outputs are settled 1 time unit after the edge.
    task automatic step(input logic wv, input logic rv, input logic cv, input logic [DW-1:0] dv);
        w = wv;
        r = rv;
        c = cv;
        d = dv;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTn = 1'b0;
        w = 1'b0;
        r = 1'b0;
        c = 1'b0;
        d = 8'h00;
        #3;
        chk("rst_empty",  32'(if0.empty),        32'h1);
        chk("rst_ae",     32'(if0.almost_empty), 32'h1);
        chk("rst_full",   32'(if0.full),         32'h0);
        chk("rst_af",     32'(if0.almost_full),  32'h0);
        chk("rst_count",  32'(if0.count),        32'h0);
        chk("rst_valid",  32'(if0.valid),        32'h0);
        chk("rst_oData",  32'(if0.oData),        32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // 1: fill with 0x01..0x10
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i + 1));
            chk("t1_count", 32'(if0.count),        32'(i + 1));
            chk("t1_ae",    32'(if0.almost_empty), 32'((i + 1) <= 2));
            chk("t1_af",    32'(if0.almost_full),  32'((i + 1) >= 14));
        end
        chk("t1_full", 32'(if0.full),     32'h1);
        chk("t1_ovf",  32'(if0.overflow), 32'h0);

        // 2: overflow attempt, then drain in order
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        chk("t2_ovf",   32'(if0.overflow), 32'h1);
        chk("t2_count", 32'(if0.count),    32'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            chk("t2_oData", 32'(if0.oData), 32'(i + 1));
            chk("t2_valid", 32'(if0.valid), 32'h1);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t2_valid_end", 32'(if0.valid), 32'h0);
        chk("t2_empty",     32'(if0.empty), 32'h1);

        // 3: preload 5, then 40 cycles of simultaneous push/pop
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(8'h45 + i));
            chk("t3_oData", 32'(if0.oData), 32'(8'h40 + i));
            chk("t3_count", 32'(if0.count), 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            chk("t3_drain", 32'(if0.oData), 32'(8'h68 + i));
        end

        // 4: underflow, clear racing a new underflow, then a plain clear
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t4_unf",   32'(if0.underflow), 32'h1);
        chk("t4_hold",  32'(if0.oData),     32'h6C);
        chk("t4_valid", 32'(if0.valid),     32'h0);
        chk("t4_count", 32'(if0.count),     32'h0);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        chk("t4_unf_setwins", 32'(if0.underflow), 32'h1);
        chk("t4_ovf_clr",     32'(if0.overflow),  32'h0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t4_unf_clr", 32'(if0.underflow), 32'h0);

        // 5: FWFT view of a single word
        step(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("t5_fwft_data",  32'(if1.oData), 32'h3C);
        chk("t5_fwft_valid", 32'(if1.valid), 32'h1);
        chk("t5_reg_valid",  32'(if0.valid), 32'h0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t5_fwft_zero",  32'(if1.oData), 32'h0);
        chk("t5_fwft_inval", 32'(if1.valid), 32'h0);
        chk("t5_reg_data",   32'(if0.oData), 32'h3C);

        // 6: mid-operation asynchronous reset
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        w = 1'b0;
        chk("t6_pre_count", 32'(if0.count),     32'd7);
        chk("t6_pre_unf",   32'(if0.underflow), 32'h1);
        #1;
        RSTn = 1'b0;
        #1;
        chk("t6_count",  32'(if0.count),        32'h0);
        chk("t6_empty",  32'(if0.empty),        32'h1);
        chk("t6_ae",     32'(if0.almost_empty), 32'h1);
        chk("t6_af",     32'(if0.almost_full),  32'h0);
        chk("t6_unf",    32'(if0.underflow),    32'h0);
        chk("t6_oData",  32'(if0.oData),        32'h0);
        chk("t6_fwft_v", 32'(if1.valid),        32'h0);
        chk("t6_fwft_d", 32'(if1.oData),        32'h0);
        RSTn = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("t6_post_unf",   32'(if0.underflow), 32'h1);
        chk("t6_post_count", 32'(if0.count),     32'h0);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
